fwd_bypass_unit: RTL and testbench

//  Parametrised operand-select successor for the pipelined CPU.
//  - Tracks in-flight GRF writes in a DEPTH-entry shift pipeline (E/M/W for DEPTH=3).
//  - Per read port, selects the youngest forwarded value, or the GRF value when nothing matches.
//  - Raises stall when the matching producer has no data yet.
//  - Sits between D-stage GRF reads and the E-stage operand registers.

---
 rtl/fwd_bypass_unit.sv | 198 +++++++++++++++++++
 tb/tb_fwd_bypass_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_bypass_unit.sv
// -----------------------------------------------------------------------------
// fwd_bypass_unit
//
// Operand-select / forwarding unit for the pipelined CPU. It sits between the
// D-stage GRF reads and the E-stage operand registers. It tracks in-flight
// register writes in a DEPTH-entry shift pipeline. Entry 0 is the youngest (E)
// and entry DEPTH-1 is the oldest (W).
//
// Each read port receives one of the following:
//   - the youngest matching in-flight value;
//   - the raw GRF value, when nothing matches;
//   - a stall request, when the youngest matching producer has no data yet.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low (0 = flush at next clk edge)
//   issue_valid  D-stage instruction present
//   issue_a3     its destination register (0 = no write)
//   issue_rdy    its result is already known at issue
//   issue_wd     that result (only used when issue_rdy)
//   fill_en      bit k: entry k's result is produced this cycle
//   fill_data    slice k: result for entry k
//   rd_a         read addresses, AW bits per port
//   rd_grf       raw GRF read data, WIDTH bits per port
//   rd_data      selected operand per port (combinational)
//   stall        hold D/F, bubble into E (combinational)
//   retire_en    oldest entry writes the GRF this cycle
//   retire_a3    its address (0 when retire_en=0)
//   retire_wd    its data (0 when retire_en=0)
//   retire_err   sticky: an unfilled write reached the oldest entry
//   stall_cnt    saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_bypass_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NRD   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_a3,
  input  logic                   issue_rdy,
  input  logic [WIDTH-1:0]       issue_wd,
  input  logic [DEPTH-1:0]       fill_en,
  input  logic [DEPTH*WIDTH-1:0] fill_data,
  input  logic [NRD*AW-1:0]      rd_a,
  input  logic [NRD*WIDTH-1:0]   rd_grf,
  output logic [NRD*WIDTH-1:0]   rd_data,
  output logic                   stall,
  output logic                   retire_en,
  output logic [AW-1:0]          retire_a3,
  output logic [WIDTH-1:0]       retire_wd,
  output logic                   retire_err,
  output logic [31:0]            stall_cnt
);

  // In-flight entry fields
  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] rdy_reg;
  logic [AW-1:0]    a3_reg   [DEPTH];
  logic [WIDTH-1:0] data_reg [DEPTH];

  logic [NRD-1:0]   stall_req;
  logic             retire_err_reg;
  logic [31:0]      stall_cnt_reg;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Per-port match and select
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_port
      logic [AW-1:0]    port_a;
      logic             hit;
      logic             hit_rdy;
      logic [WIDTH-1:0] hit_data;

      assign port_a = rd_a[gi*AW +: AW];

      // Scan from the oldest entry to the youngest.
      // The last hit overwrites the earlier ones, so the youngest match wins.
      // An older ready value can therefore never mask a younger unready one.
      always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (v_reg[k] && (a3_reg[k] != '0) && (a3_reg[k] == port_a)) begin
            hit      = 1'b1;
            hit_rdy  = rdy_reg[k];
            hit_data = data_reg[k];
          end
        end
      end

      // Hits imply port_a != 0, so register 0 never requests a stall.
      assign stall_req[gi] = hit & ~hit_rdy;

      assign rd_data[gi*WIDTH +: WIDTH] =
        (port_a == '0)     ? '0       :
        (hit && hit_rdy)   ? hit_data :
                             rd_grf[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign stall = issue_valid & (|stall_req);

  // ---------------------------------------------------------------------------
  // Entry 0: takes the issuing instruction, or a bubble while stalled
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_reg[0]    <= 1'b0;
      a3_reg[0]   <= '0;
      rdy_reg[0]  <= 1'b0;
      data_reg[0] <= '0;
    end else if (stall) begin
      v_reg[0]    <= 1'b0;
      a3_reg[0]   <= '0;
      rdy_reg[0]  <= 1'b0;
      data_reg[0] <= '0;
    end else begin
      v_reg[0]    <= issue_valid;
      a3_reg[0]   <= issue_a3;
      rdy_reg[0]  <= issue_rdy;
      data_reg[0] <= issue_rdy ? issue_wd : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Entries 1..DEPTH-1: unconditional shift.
  // A fill lands on the entry as it moves, so it becomes visible to
  // forwarding one cycle after fill_en.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (!reset) begin
          v_reg[gi]    <= 1'b0;
          a3_reg[gi]   <= '0;
          rdy_reg[gi]  <= 1'b0;
          data_reg[gi] <= '0;
        end else begin
          v_reg[gi]  <= v_reg[gi-1];
          a3_reg[gi] <= a3_reg[gi-1];
          if (fill_en[gi-1] && v_reg[gi-1]) begin
            rdy_reg[gi]  <= 1'b1;
            data_reg[gi] <= fill_data[(gi-1)*WIDTH +: WIDTH];
          end else begin
            rdy_reg[gi]  <= rdy_reg[gi-1];
            data_reg[gi] <= data_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // The oldest entry leaves the pipeline at the next edge.
  // A fill aimed at it has nowhere to land.
  logic unused_fill;
  assign unused_fill = ^{fill_en[DEPTH-1], fill_data[(DEPTH-1)*WIDTH +: WIDTH]};

  // ---------------------------------------------------------------------------
  // Retire from the oldest entry
  // ---------------------------------------------------------------------------
  logic oldest_writes;
  assign oldest_writes = v_reg[DEPTH-1] & (a3_reg[DEPTH-1] != '0);

  assign retire_en = oldest_writes & rdy_reg[DEPTH-1];
  assign retire_a3 = retire_en ? a3_reg[DEPTH-1]   : '0;
  assign retire_wd = retire_en ? data_reg[DEPTH-1] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_err_reg <= 1'b0;
    end else if (oldest_writes && !rdy_reg[DEPTH-1]) begin
      retire_err_reg <= 1'b1;
    end
  end

  assign retire_err = retire_err_reg;

  // ---------------------------------------------------------------------------
  // Stall cycle counter; it sticks at all-ones instead of wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_bypass_unit
//
// Directed testbench for fwd_bypass_unit with the default parameters
// (WIDTH=32, AW=5, DEPTH=3, NRD=2).
// Inputs change 1 time unit after a rising edge.
// Outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_fwd_bypass_unit;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NRD   = 2;

  logic                   clk;
  logic                   reset;
  logic                   issue_valid;
  logic [AW-1:0]          issue_a3;
  logic                   issue_rdy;
  logic [WIDTH-1:0]       issue_wd;
  logic [DEPTH-1:0]       fill_en;
  logic [DEPTH*WIDTH-1:0] fill_data;
  logic [NRD*AW-1:0]      rd_a;
  logic [NRD*WIDTH-1:0]   rd_grf;
  logic [NRD*WIDTH-1:0]   rd_data;
  logic                   stall;
  logic                   retire_en;
  logic [AW-1:0]          retire_a3;
  logic [WIDTH-1:0]       retire_wd;
  logic                   retire_err;
  logic [31:0]            stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  fwd_bypass_unit #(
    .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .NRD(NRD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_a3   (issue_a3),
    .issue_rdy  (issue_rdy),
    .issue_wd   (issue_wd),
    .fill_en    (fill_en),
    .fill_data  (fill_data),
    .rd_a       (rd_a),
    .rd_grf     (rd_grf),
    .rd_data    (rd_data),
    .stall      (stall),
    .retire_en  (retire_en),
    .retire_a3  (retire_a3),
    .retire_wd  (retire_wd),
    .retire_err (retire_err),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("ok   %-22s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may be changed right after returning.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] a3, input logic r,
                       input logic [WIDTH-1:0] wd);
    issue_valid = v;
    issue_a3    = a3;
    issue_rdy   = r;
    issue_wd    = wd;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] grf);
    rd_a[p*AW +: AW]         = a;
    rd_grf[p*WIDTH +: WIDTH] = grf;
  endtask

  initial begin
    reset     = 1'b0;
    issue(1'b0, '0, 1'b0, '0);
    fill_en   = '0;
    fill_data = '0;
    rd_a      = '0;
    rd_grf    = '0;

    // ---- 1. reset, then empty pipeline passes GRF through -------------------
    tick();
    reset = 1'b1;
    issue(1'b1, 5'd0, 1'b0, '0);
    set_port(0, 5'd3, 32'hAAAA_0001);
    set_port(1, 5'd4, 32'h5555_0002);
    @(negedge clk);
    check("rst_rd0",       rd_data[31:0],  32'hAAAA_0001);
    check("rst_rd1",       rd_data[63:32], 32'h5555_0002);
    check("rst_stall",     stall,          1'b0);
    check("rst_stall_cnt", stall_cnt,      32'd0);
    check("rst_retire_en", retire_en,      1'b0);
    check("rst_retire_err",retire_err,     1'b0);
    issue(1'b0, '0, 1'b0, '0);
    tick();

    // ---- 2. ready write forwarded next cycle, retires DEPTH-1 edges later --
    issue(1'b1, 5'd8, 1'b1, 32'h1234);
    set_port(0, 5'd0, 32'h0);
    set_port(1, 5'd0, 32'h0);
    tick();
    issue(1'b1, 5'd0, 1'b0, '0);
    set_port(0, 5'd8, 32'h0);
    set_port(1, 5'd0, 32'h3333);
    @(negedge clk);
    check("fwd_ready_rd0",  rd_data[31:0],  32'h1234);
    check("fwd_zero_rd1",   rd_data[63:32], 32'h0);
    check("fwd_ready_stall",stall,          1'b0);
    tick();
    tick();
    @(negedge clk);
    check("retire8_en", retire_en, 1'b1);
    check("retire8_a3", retire_a3, 5'd8);
    check("retire8_wd", retire_wd, 32'h1234);

    // ---- 3. load-use stall, fill, then forward of filled data --------------
    tick();
    issue(1'b1, 5'd9, 1'b0, 32'hDEAD);
    set_port(0, 5'd0, 32'h0);
    set_port(1, 5'd0, 32'h0);
    tick();                                   // load now entry 0
    issue(1'b0, 5'd0, 1'b0, '0);
    tick();                                   // load now entry 1
    issue(1'b1, 5'd10, 1'b1, 32'h77);
    set_port(0, 5'd9, 32'h1111);
    fill_en   = 3'b010;
    fill_data = '0;
    fill_data[63:32] = 32'hBEEF;
    @(negedge clk);
    check("load_stall",     stall,         1'b1);
    check("load_rd0_grf",   rd_data[31:0], 32'h1111);
    check("load_cnt0",      stall_cnt,     32'd0);
    tick();                                   // bubble in, load filled at entry 2
    fill_en   = '0;
    fill_data = '0;
    @(negedge clk);
    check("filled_rd0",     rd_data[31:0], 32'hBEEF);
    check("filled_stall",   stall,         1'b0);
    check("filled_cnt",     stall_cnt,     32'd1);
    check("retire9_en",     retire_en,     1'b1);
    check("retire9_a3",     retire_a3,     5'd9);
    check("retire9_wd",     retire_wd,     32'hBEEF);
    tick();                                   // a3=10 issued into entry 0
    issue(1'b0, 5'd0, 1'b0, '0);
    set_port(1, 5'd10, 32'h0);
    @(negedge clk);
    check("fwd10_rd1",      rd_data[63:32], 32'h77);
    check("gone9_rd0",      rd_data[31:0],  32'h1111);

    // ---- 4. younger unready shadows older ready; rd_a=0 reads 0 ------------
    set_port(0, 5'd0, 32'h0);
    set_port(1, 5'd0, 32'h0);
    issue(1'b1, 5'd5, 1'b1, 32'h1);
    tick();
    issue(1'b1, 5'd0, 1'b0, '0);
    tick();
    issue(1'b1, 5'd5, 1'b0, '0);
    tick();                                   // e0=(5,unready) e1=(v,a3=0) e2=(5,ready,1)
    issue(1'b1, 5'd0, 1'b0, '0);
    set_port(0, 5'd5, 32'h2222);
    set_port(1, 5'd0, 32'h3333);
    @(negedge clk);
    check("shadow_stall",   stall,          1'b1);
    check("shadow_rd0",     rd_data[31:0],  32'h2222);
    check("a3zero_rd1",     rd_data[63:32], 32'h0);
    check("retire5_en",     retire_en,      1'b1);
    check("retire5_wd",     retire_wd,      32'h1);
    check("shadow_cnt",     stall_cnt,      32'd1);

    // ---- 5. stall counter saturation, unfilled load at the oldest entry ----
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    tick();                                   // stall 1
    @(negedge clk);
    check("sat_stall1",     stall,     1'b1);
    check("sat_cnt1",       stall_cnt, 32'hFFFF_FFFF);
    tick();                                   // stall 2, load at oldest entry
    @(negedge clk);
    check("sat_stall2",     stall,     1'b1);
    check("sat_cnt2",       stall_cnt, 32'hFFFF_FFFF);
    check("unready_ret_en", retire_en, 1'b0);
    check("unready_ret_a3", retire_a3, 5'd0);
    check("unready_ret_wd", retire_wd, 32'h0);
    check("err_not_yet",    retire_err, 1'b0);
    tick();                                   // stall 3, load dropped out
    @(negedge clk);
    check("sat_cnt3",       stall_cnt,     32'hFFFF_FFFF);
    check("retire_err_set", retire_err,    1'b1);
    check("drain_stall",    stall,         1'b0);
    check("drain_rd0",      rd_data[31:0], 32'h2222);

    // ---- 6. reset in the middle of a stall with three valid entries --------
    set_port(0, 5'd0, 32'h0);
    set_port(1, 5'd0, 32'h0);
    issue(1'b1, 5'd6, 1'b0, '0);
    tick();
    issue(1'b1, 5'd7, 1'b1, 32'h99);
    tick();
    issue(1'b1, 5'd12, 1'b1, 32'hAB);
    tick();                                   // e0=12 e1=7 e2=(6,unready)
    issue(1'b1, 5'd0, 1'b0, '0);
    set_port(0, 5'd6, 32'h4444);
    set_port(1, 5'd7, 32'h5555);
    @(negedge clk);
    check("pre_rst_stall",  stall,          1'b1);
    check("pre_rst_rd1",    rd_data[63:32], 32'h99);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_stall", stall,          1'b0);
    check("post_rst_ret",   retire_en,      1'b0);
    check("post_rst_rd0",   rd_data[31:0],  32'h4444);
    check("post_rst_rd1",   rd_data[63:32], 32'h5555);
    check("post_rst_err",   retire_err,     1'b0);
    check("post_rst_cnt",   stall_cnt,      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
